// File: rtl/rng_share_arbiter.sv
// rng_share_arbiter: schedules the single 64-bit prng_lcg of the BIKE-2
// key-generation datapath among N_REQ sampler requesters. The prng is seeded
// first (and again on every later seed_load); random-word requests are then
// served round-robin, with only one prng operation outstanding at a time.
// Optional build macro RNG_TIMEOUT_EN adds a WAIT watchdog and the sticky
// timeout_err output; without it WAIT waits for rng_valid indefinitely.
module rng_share_arbiter #(
  parameter int N_REQ   = 3,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             seed_load,
  input  logic [63:0]      seed_in,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [63:0]      rnd_out,
  output logic             seeded,
  output logic             busy,
  output logic [1:0]       rng_start,
  output logic [63:0]      rng_seed,
  input  logic             rng_valid,
  input  logic [63:0]      rng_in
`ifdef RNG_TIMEOUT_EN
  ,
  output logic             timeout_err
`endif
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_GEN  = 2'b01;
  localparam logic [1:0] CMD_SEED = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEED  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_GRANT = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               op_seed_q, op_seed_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               seed_pend_q, seed_pend_d;
  logic               seeded_q, seeded_d;
  logic [63:0]        rnd_q, rnd_d;
  logic [63:0]        seed_q, seed_d;
  // A seed_load arriving while a seed op is in flight must not disturb
  // rng_seed; its value is parked here until the next SEED.
  logic               defer_q, defer_d;
  logic [63:0]        defer_seed_q, defer_seed_d;

  logic [PTR_W-1:0]   pick;
  logic [PTR_W-1:0]   idx;
  logic               pick_vld;
  logic               seed_op_active;

`ifdef RNG_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tmo_q, tmo_d;
`endif

  assign seed_op_active = (state_q == S_SEED) || ((state_q == S_WAIT) && op_seed_q);

  // Round-robin pick: first set request at or after ptr_q, wrapping around.
  always_comb begin
    pick     = ptr_q;
    pick_vld = 1'b0;
    idx      = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = PTR_W'((int'(ptr_q) + i) % N_REQ);
      if (req[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  // Next-state and command/grant decode.
  always_comb begin
    state_d      = state_q;
    op_seed_d    = op_seed_q;
    owner_d      = owner_q;
    ptr_d        = ptr_q;
    seed_pend_d  = seed_pend_q;
    seeded_d     = seeded_q;
    rnd_d        = rnd_q;
    seed_d       = seed_q;
    defer_d      = defer_q;
    defer_seed_d = defer_seed_q;
    gnt          = '0;
    rng_start    = CMD_IDLE;
`ifdef RNG_TIMEOUT_EN
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
`endif

    case (state_q)
      S_IDLE: begin
        // A seed_load in this very cycle also beats a simultaneous request.
        if (seed_pend_q || seed_load) begin
          state_d = S_SEED;
          if (defer_q) begin
            seed_d  = defer_seed_q;
            defer_d = 1'b0;
          end
        end else if (seeded_q && pick_vld) begin
          owner_d = pick;
          state_d = S_ISSUE;
        end
      end
      S_SEED: begin
        rng_start   = CMD_SEED;
        seed_pend_d = 1'b0;
        op_seed_d   = 1'b1;
        state_d     = S_WAIT;
`ifdef RNG_TIMEOUT_EN
        cnt_d       = '0;
`endif
      end
      S_ISSUE: begin
        rng_start = CMD_GEN;
        op_seed_d = 1'b0;
        state_d   = S_WAIT;
`ifdef RNG_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      S_WAIT: begin
        if (rng_valid) begin
          if (op_seed_q) begin
            seeded_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            rnd_d   = rng_in;
            state_d = S_GRANT;
          end
        end
`ifdef RNG_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // prng never answered: give up, and retry a lost seed later.
          tmo_d   = 1'b1;
          state_d = S_IDLE;
          if (op_seed_q) seed_pend_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_GRANT: begin
        gnt[owner_q] = 1'b1;
        ptr_d        = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // seed_load is honoured in every state; it overrides the SEED clear.
    if (seed_load) begin
      seed_pend_d = 1'b1;
      if (seed_op_active) begin
        defer_d      = 1'b1;
        defer_seed_d = seed_in;
      end else begin
        seed_d  = seed_in;
        defer_d = 1'b0;
      end
    end
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q      <= S_IDLE;
      op_seed_q    <= 1'b0;
      owner_q      <= '0;
      ptr_q        <= '0;
      seed_pend_q  <= 1'b0;
      seeded_q     <= 1'b0;
      rnd_q        <= '0;
      seed_q       <= '0;
      defer_q      <= 1'b0;
      defer_seed_q <= '0;
`ifdef RNG_TIMEOUT_EN
      cnt_q        <= '0;
      tmo_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      op_seed_q    <= op_seed_d;
      owner_q      <= owner_d;
      ptr_q        <= ptr_d;
      seed_pend_q  <= seed_pend_d;
      seeded_q     <= seeded_d;
      rnd_q        <= rnd_d;
      seed_q       <= seed_d;
      defer_q      <= defer_d;
      defer_seed_q <= defer_seed_d;
`ifdef RNG_TIMEOUT_EN
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
`endif
    end
  end

  assign rnd_out  = rnd_q;
  assign seeded   = seeded_q;
  assign busy     = (state_q != S_IDLE);
  assign rng_seed = seed_q;
`ifdef RNG_TIMEOUT_EN
  assign timeout_err = tmo_q;
`endif

endmodule

// File: doc/rng_share_arbiter.md
Name: rng_share_arbiter

Overview:
- Schedules the single 64-bit prng_lcg instance in the BIKE-2 key-generation datapath and shares it among N_REQ sampler requesters (e.g. f0, f1 and g samplers).
- Performs a one-time seed load, then serves 64-bit random-word requests round-robin.
- Drives the prng's 2-bit start command and waits on its valid strobe.
- Returns each word to exactly one requester with a one-cycle grant.

Parameters:
N_REQ, 3, number of requesters (2..8).
TIMEOUT, 255, max cycles waited for rng_valid; used only with RNG_TIMEOUT_EN.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst_b  in  1  synchronous, active-high reset.
seed_load  in  1  one-cycle pulse: reseed prng with seed_in.
seed_in  in  64  seed value, sampled on the seed_load cycle.
req  in  N_REQ  per-requester request level; held until its gnt.
gnt  out  N_REQ  one-hot, one-cycle pulse; rnd_out is valid in the same cycle.
rnd_out  out  64  random word delivered with gnt.
seeded  out  1  high once the first seed completes.
busy  out  1  high in any state other than IDLE.
rng_start  out  2  to prng: 00 idle, 01 generate, 10 load seed (rng_seed); one-cycle pulse.
rng_seed  out  64  seed presented to prng; held stable from the 10 pulse until its rng_valid.
rng_valid  in  1  prng result strobe.
rng_in  in  64  prng result word.

Behaviour:
- Reset: state IDLE. gnt=0, rnd_out=0, seeded=0, busy=0, rng_start=00, rng_seed=0, rr pointer=0, seed_pend=0.
- Reset applies mid-transaction and abandons any outstanding prng operation.
- seed_load in any state sets seed_pend and latches seed_in into rng_seed.
- A later seed_load overwrites rng_seed only while the SEED/WAIT of a seed operation is not in progress. Otherwise it stays pending.
- States:
  - IDLE:
    - If seed_pend: go to SEED. Seed has priority over requests.
    - Else if seeded and any req bit set: choose the first set bit at or after the rr pointer (circular); register owner; go to ISSUE.
    - Requests arriving while seeded=0 are held, not served.
  - SEED: rng_start=10 for exactly this cycle; clear seed_pend; op=seed; go to WAIT.
  - ISSUE: rng_start=01 for exactly this cycle; op=gen; go to WAIT.
  - WAIT:
    - rng_start=00.
    - On rng_valid=1 with op=seed: set seeded=1; go to IDLE.
    - On rng_valid=1 with op=gen: rnd_out<=rng_in; go to GRANT.
    - rng_valid outside WAIT is ignored.
  - GRANT:
    - gnt[owner]=1 for exactly this cycle; rnd_out holds the word.
    - rr pointer <= (owner+1) mod N_REQ.
    - Go to IDLE. The requester's req may still be high this cycle and is not sampled.
- Latency:
  - req (idle, seeded, highest priority) seen at edge t gives rng_start=01 in cycle t+1.
  - rng_valid in cycle v gives gnt in cycle v+1.
  - Minimum req-to-gnt with a 1-cycle prng: 4 cycles.
- rnd_out holds its last value until the next grant.
- req deasserted before grant: the transaction still completes, and gnt pulses to that owner anyway. Requesters must not withdraw requests.
- Simultaneous seed_load and req in IDLE: seed wins; the request is served after seeding.
- Only one prng operation is outstanding at any time.

Optional Feature:
- Macro: RNG_TIMEOUT_EN.
- When defined:
  - Adds output timeout_err (1 bit, reset 0, sticky until reset).
  - A counter clears on WAIT entry and increments each WAIT cycle.
  - If it reaches TIMEOUT without rng_valid: set timeout_err and go to IDLE.
  - No gnt is issued. For op=seed, seeded is not set and seed_pend is set again for a retry.
- When undefined: no port or counter exists; WAIT waits indefinitely.

Test Plan:
- Reset, then seed_load with seed_in=64'd1234 -> one cycle of rng_start=10 with rng_seed=1234; seeded=1 the cycle after rng_valid; no gnt.
- Before seeding, req=3'b001 held for 20 cycles -> no rng_start=01 and no gnt; after seeding, gnt=3'b001 with rnd_out equal to the rng_in captured.
- req=3'b111 held continuously, with requesters dropping req on their grant -> grant order 001, 010, 100; each gnt exactly one cycle; no requester granted twice.
- req=3'b101 with pointer=1 -> requester 2 granted first, then requester 0.
- seed_load pulsed during WAIT of a gen op -> gen completes and is granted first, then rng_start=10 issued; rng_seed keeps its value through the seed op.
- With RNG_TIMEOUT_EN and TIMEOUT=8, prng rng_valid forced low -> timeout_err=1 eight cycles after WAIT entry, state returns to IDLE, no gnt; rst_b high clears all outputs on the next edge.
